// File: rtl/gelato_ifetch.sv
// gelato_ifetch: instruction fetch stage with a single fetch in flight.
// Takes one warp PC from the fetch scheduler, reads one instruction word,
// hands it to decode over valid/ready and then pulses an activate back to
// the PC table so the warp can be scheduled again. A misaligned PC skips
// the memory read and is delivered as a faulting, zero instruction.
// A low rdy freezes every flop, which also stretches the one-cycle pulses.
`timescale 1ns/1ps

module gelato_ifetch #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int WARP_W  = 5,
    parameter int SPLIT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               pc_valid,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [WARP_W-1:0]  pc_warp_num,
    input  logic [SPLIT_W-1:0] pc_split_num,
    output logic               pc_caught,
    output logic               mem_req_valid,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_rsp_valid,
    input  logic [INST_W-1:0]  mem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INST_W-1:0]  inst,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic [WARP_W-1:0]  inst_warp_num,
    output logic [SPLIT_W-1:0] inst_split_num,
    output logic               inst_fault,
    output logic               activate_valid,
    output logic [WARP_W-1:0]  activate_warp,
    input  logic               flush
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t               state_q,          state_d;
    logic [ADDR_W-1:0]    pc_q,             pc_d;
    logic [WARP_W-1:0]    warp_q,           warp_d;
    logic [SPLIT_W-1:0]   split_q,          split_d;
    logic                 pc_caught_q,      pc_caught_d;
    logic                 mem_req_valid_q,  mem_req_valid_d;
    logic [INST_W-1:0]    inst_q,           inst_d;
    logic                 inst_valid_q,     inst_valid_d;
    logic                 inst_fault_q,     inst_fault_d;
    logic                 activate_valid_q, activate_valid_d;
    logic [WARP_W-1:0]    activate_warp_q,  activate_warp_d;
    logic                 rsp_expected_s;

    // Next-state and next-output computation; everything holds while rdy is low.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        warp_d           = warp_q;
        split_d          = split_q;
        pc_caught_d      = pc_caught_q;
        mem_req_valid_d  = mem_req_valid_q;
        inst_d           = inst_q;
        inst_valid_d     = inst_valid_q;
        inst_fault_d     = inst_fault_q;
        activate_valid_d = activate_valid_q;
        activate_warp_d  = activate_warp_q;
        if (rdy) begin
            // Pulses last one enabled cycle.
            pc_caught_d      = 1'b0;
            activate_valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pc_valid && !flush) begin
                        pc_d        = pc;
                        warp_d      = pc_warp_num;
                        split_d     = pc_split_num;
                        pc_caught_d = 1'b1;
                        if (pc[1:0] != 2'b00) begin
                            // Misaligned: never touch memory, deliver a fault.
                            inst_d       = {INST_W{1'b0}};
                            inst_valid_d = 1'b1;
                            inst_fault_d = 1'b1;
                            state_d      = S_OUT;
                        end else begin
                            mem_req_valid_d = 1'b1;
                            state_d         = S_REQ;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        mem_req_valid_d = 1'b0;
                        if (mem_req_ready) begin
                            // Request already issued: its response must be drained.
                            state_d = S_DRAIN;
                        end else begin
                            activate_valid_d = 1'b1;
                            activate_warp_d  = warp_q;
                            state_d          = S_IDLE;
                        end
                    end else if (mem_req_ready) begin
                        mem_req_valid_d = 1'b0;
                        state_d         = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (flush && mem_rsp_valid) begin
                        // Response arrives with the flush: consume and drop it now.
                        activate_valid_d = 1'b1;
                        activate_warp_d  = warp_q;
                        state_d          = S_IDLE;
                    end else if (flush) begin
                        state_d = S_DRAIN;
                    end else if (mem_rsp_valid) begin
                        inst_d       = mem_rsp_data;
                        inst_valid_d = 1'b1;
                        inst_fault_d = 1'b0;
                        state_d      = S_OUT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_OUT: begin
                    if (flush || inst_ready) begin
                        inst_valid_d     = 1'b0;
                        activate_valid_d = 1'b1;
                        activate_warp_d  = warp_q;
                        state_d          = S_IDLE;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                S_DRAIN: begin
                    if (mem_rsp_valid) begin
                        activate_valid_d = 1'b1;
                        activate_warp_d  = warp_q;
                        state_d          = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d         = S_IDLE;
                    mem_req_valid_d = 1'b0;
                    inst_valid_d    = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            pc_q             <= {ADDR_W{1'b0}};
            warp_q           <= {WARP_W{1'b0}};
            split_q          <= {SPLIT_W{1'b0}};
            pc_caught_q      <= 1'b0;
            mem_req_valid_q  <= 1'b0;
            inst_q           <= {INST_W{1'b0}};
            inst_valid_q     <= 1'b0;
            inst_fault_q     <= 1'b0;
            activate_valid_q <= 1'b0;
            activate_warp_q  <= {WARP_W{1'b0}};
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            warp_q           <= warp_d;
            split_q          <= split_d;
            pc_caught_q      <= pc_caught_d;
            mem_req_valid_q  <= mem_req_valid_d;
            inst_q           <= inst_d;
            inst_valid_q     <= inst_valid_d;
            inst_fault_q     <= inst_fault_d;
            activate_valid_q <= activate_valid_d;
            activate_warp_q  <= activate_warp_d;
        end
    end

    assign pc_caught      = pc_caught_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_addr   = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = pc_q;
    assign inst_warp_num  = warp_q;
    assign inst_split_num = split_q;
    assign inst_fault     = inst_fault_q;
    assign activate_valid = activate_valid_q;
    assign activate_warp  = activate_warp_q;

    assign rsp_expected_s = (state_q == S_WAIT) || (state_q == S_DRAIN);

    gelato_ifetch_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .mem_rsp_valid (mem_rsp_valid),
        .rsp_expected  (rsp_expected_s)
    );

endmodule

// Protocol checker: a memory response is only legal while one is outstanding.
module gelato_ifetch_chk (
    input logic clk,
    input logic rst,
    input logic mem_rsp_valid,
    input logic rsp_expected
);

    // Flag any read response that arrives with no request outstanding.
    always @(posedge clk) begin
        if (!rst && mem_rsp_valid) begin
            assert (rsp_expected)
            else $error("gelato_ifetch: mem_rsp_valid with no outstanding request");
        end
    end

endmodule
